// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating IF fetches and MEM loads/stores onto one 8-bit sync RAM port.
// Optional macro MEMCTRL_IO_STALL_EN: stalls writes to addresses >= IO_BASE while io_buffer_full is high.
module mem_ctrl #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  IO_BASE    = ADDR_WIDTH'(32'h00030000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic [31:0]           if_data,
  output logic [1:0]            if_status,
  input  logic [2:0]            mem_rw,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_quantity,
  output logic [31:0]           mem_rdata,
  output logic [1:0]            mem_status,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [7:0]            ram_dout,
  output logic                  ram_wr,
  input  logic [7:0]            ram_din,
  input  logic                  io_buffer_full
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;

  localparam logic [1:0] STAT_IDLE = 2'b00;
  localparam logic [1:0] STAT_BUSY = 2'b01;
  localparam logic [1:0] STAT_DONE = 2'b10;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [2:0]            qty_q;
  logic                  owner_if_q;
  logic [2:0]            cnt_q;
  logic [31:0]           rbuf_q;
  logic [ADDR_WIDTH-1:0] ram_a_q;
  logic [7:0]            ram_dout_q;
  logic                  ram_wr_q;
  logic [31:0]           if_data_q;
  logic [31:0]           mem_rdata_q;
  logic [1:0]            if_status_q;
  logic [1:0]            mem_status_q;

  logic [2:0]            mem_qty_d;
  logic [ADDR_WIDTH-1:0] cur_addr_d;
  logic [7:0]            wbyte_d;
  logic [1:0]            lane_d;
  logic [31:0]           rword_d;
  logic                  wr_stall_d;
  logic                  acc_stall_d;

  assign ram_a      = ram_a_q;
  assign ram_dout   = ram_dout_q;
  assign ram_wr     = ram_wr_q;
  assign if_data    = if_data_q;
  assign mem_rdata  = mem_rdata_q;
  assign if_status  = if_status_q;
  assign mem_status = mem_status_q;

  always_comb begin
    case (mem_quantity)
      4'd1:    mem_qty_d = 3'd1;
      4'd2:    mem_qty_d = 3'd2;
      default: mem_qty_d = 3'd4;
    endcase
  end

  // cnt_q counts edges since acceptance; the byte issued on a read is captured two edges later.
  assign cur_addr_d = addr_q + ADDR_WIDTH'(cnt_q);
  assign wbyte_d    = wdata_q[8*cnt_q[1:0] +: 8];
  assign lane_d     = 2'(cnt_q - 3'd2);

  always_comb begin
    rword_d = rbuf_q;
    rword_d[8*lane_d +: 8] = ram_din;
  end

`ifdef MEMCTRL_IO_STALL_EN
  assign wr_stall_d  = io_buffer_full && (cur_addr_d >= IO_BASE);
  assign acc_stall_d = io_buffer_full && (mem_addr >= IO_BASE);
`else
  logic unused_io;
  assign wr_stall_d  = 1'b0;
  assign acc_stall_d = 1'b0;
  assign unused_io   = io_buffer_full ^ (^IO_BASE);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      qty_q        <= '0;
      owner_if_q   <= 1'b0;
      cnt_q        <= '0;
      rbuf_q       <= '0;
      ram_a_q      <= '0;
      ram_dout_q   <= '0;
      ram_wr_q     <= 1'b0;
      if_data_q    <= '0;
      mem_rdata_q  <= '0;
      if_status_q  <= STAT_IDLE;
      mem_status_q <= STAT_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q    <= 3'd1;
          rbuf_q   <= '0;
          ram_wr_q <= 1'b0;
          if (mem_rw == 3'b001) begin
            state_q      <= S_READ;
            owner_if_q   <= 1'b0;
            addr_q       <= mem_addr;
            qty_q        <= mem_qty_d;
            ram_a_q      <= mem_addr;
            mem_status_q <= STAT_BUSY;
          end else if (mem_rw == 3'b010) begin
            state_q      <= S_WRITE;
            owner_if_q   <= 1'b0;
            addr_q       <= mem_addr;
            wdata_q      <= mem_wdata;
            qty_q        <= mem_qty_d;
            ram_a_q      <= mem_addr;
            ram_dout_q   <= mem_wdata[7:0];
            mem_status_q <= STAT_BUSY;
            if (acc_stall_d) begin
              cnt_q <= 3'd0;
            end else begin
              ram_wr_q <= 1'b1;
            end
          end else if (if_req) begin
            state_q     <= S_READ;
            owner_if_q  <= 1'b1;
            addr_q      <= if_addr;
            qty_q       <= 3'd4;
            ram_a_q     <= if_addr;
            if_status_q <= STAT_BUSY;
          end
        end

        S_READ: begin
          if (owner_if_q && if_flush) begin
            state_q     <= S_IDLE;
            if_status_q <= STAT_IDLE;
          end else begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q < qty_q) begin
              ram_a_q <= cur_addr_d;
            end
            if (cnt_q >= 3'd2) begin
              rbuf_q <= rword_d;
            end
            if (cnt_q == qty_q + 3'd1) begin
              state_q <= S_DONE;
              if (owner_if_q) begin
                if_data_q   <= rword_d;
                if_status_q <= STAT_DONE;
              end else begin
                mem_rdata_q  <= rword_d;
                mem_status_q <= STAT_DONE;
              end
            end
          end
        end

        S_WRITE: begin
          if (cnt_q < qty_q) begin
            ram_a_q    <= cur_addr_d;
            ram_dout_q <= wbyte_d;
            if (wr_stall_d) begin
              ram_wr_q <= 1'b0;
            end else begin
              ram_wr_q <= 1'b1;
              cnt_q    <= cnt_q + 3'd1;
            end
          end else begin
            ram_wr_q     <= 1'b0;
            state_q      <= S_DONE;
            mem_status_q <= STAT_DONE;
          end
        end

        S_DONE: begin
          state_q      <= S_IDLE;
          if_status_q  <= STAT_IDLE;
          mem_status_q <= STAT_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model, phase-based access model checked every cycle,
// plus directed transactions with literal expectations.
module tb_mem_ctrl;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_flush = 1'b0;
  logic [31:0] if_data;
  logic [1:0]  if_status;
  logic [2:0]  mem_rw = 3'b000;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_quantity = 4'd0;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_status;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;
  logic        io_buffer_full = 1'b0;

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_data(if_data), .if_status(if_status),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_quantity(mem_quantity), .mem_rdata(mem_rdata), .mem_status(mem_status),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- RAM model (1 KiB, address bits 9:0) ----------------
  function automatic logic [7:0] init_byte(input logic [9:0] a);
    if (a < 10'h8) return 8'(a) + 8'd1;
    case (a)
      10'h100: return 8'h11;
      10'h101: return 8'h22;
      10'h102: return 8'h33;
      10'h103: return 8'h44;
      10'h010: return 8'hAA;
      10'h011: return 8'hBB;
      10'h020: return 8'hEF;
      10'h021: return 8'hBE;
      10'h022: return 8'hAD;
      10'h023: return 8'hDE;
      10'h3FF: return 8'h5A;
      default: return 8'h00;
    endcase
  endfunction

  logic [7:0] ram [0:1023];
  logic       ram_load = 1'b1;
  int         wr_cnt = 0;

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_byte(10'(i));
    end else if (ram_wr) begin
      ram[ram_a[9:0]] <= ram_dout;
    end
    if (ram_wr === 1'b1 && !ram_load) wr_cnt <= wr_cnt + 1;
    ram_din <= ram[ram_a[9:0]];
  end

  function automatic logic [31:0] ram_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    logic [31:0] ak;
    w = 32'h0;
    for (int k = 0; k < n; k++) begin
      ak = a + 32'(k);
      w[8*k +: 8] = ram[ak[9:0]];
    end
    return w;
  endfunction

  // ---------------- inputs as seen by the DUT at each edge ----------------
  logic        s_rst, s_ifreq, s_flush;
  logic [2:0]  s_rw;
  logic [31:0] s_maddr, s_wdata, s_ifaddr;
  logic [3:0]  s_qty;

  always @(posedge clk) begin
    s_rst   <= rst;
    s_ifreq <= if_req;
    s_flush <= if_flush;
    s_rw    <= mem_rw;
    s_maddr <= mem_addr;
    s_wdata <= mem_wdata;
    s_ifaddr <= if_addr;
    s_qty   <= mem_quantity;
  end

  // ---------------- access model: phase t since acceptance, length L ----------------
  bit          model_en = 1'b1;
  bit          m_active = 1'b0;
  bit          m_if, m_wr;
  logic [31:0] m_addr, m_wdata;
  int          m_n, m_t, m_len;
  logic [1:0]  e_ifst, e_memst;
  logic        e_wr;
  logic [31:0] e_a, e_ifdata, e_memrdata;
  logic [7:0]  e_dout;

  function automatic int qty_of(input logic [3:0] q);
    return (q == 4'd1) ? 1 : (q == 4'd2) ? 2 : 4;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (model_en) begin
        if (s_rst) begin
          m_active = 1'b0;
          e_ifst = ST_IDLE; e_memst = ST_IDLE; e_wr = 1'b0;
          e_a = 32'h0; e_dout = 8'h0; e_ifdata = 32'h0; e_memrdata = 32'h0;
        end else if (m_active) begin
          m_t++;
          e_wr = 1'b0;
          if (!m_wr && m_if && s_flush) begin
            m_active = 1'b0;
            e_ifst = ST_IDLE;
          end else if (m_t < m_len) begin
            if (m_t < m_n) begin
              e_a = m_addr + 32'(m_t);
              if (m_wr) begin
                e_wr = 1'b1;
                e_dout = m_wdata[8*m_t +: 8];
              end
            end
          end else if (m_t == m_len) begin
            if (m_wr) begin
              e_memst = ST_DONE;
            end else if (m_if) begin
              e_ifst = ST_DONE;
              e_ifdata = ram_word(m_addr, 4);
            end else begin
              e_memst = ST_DONE;
              e_memrdata = ram_word(m_addr, m_n);
            end
          end else begin
            m_active = 1'b0;
            e_ifst = ST_IDLE;
            e_memst = ST_IDLE;
          end
        end else begin
          if (s_rw == 3'b001 || s_rw == 3'b010) begin
            m_active = 1'b1; m_if = 1'b0; m_wr = (s_rw == 3'b010);
            m_addr = s_maddr; m_wdata = s_wdata; m_n = qty_of(s_qty);
            e_memst = ST_BUSY;
          end else if (s_ifreq) begin
            m_active = 1'b1; m_if = 1'b1; m_wr = 1'b0;
            m_addr = s_ifaddr; m_n = 4;
            e_ifst = ST_BUSY;
          end
          if (m_active) begin
            m_t = 0;
            m_len = m_wr ? m_n : m_n + 1;
            e_a = m_addr;
            e_wr = m_wr;
            if (m_wr) e_dout = m_wdata[7:0];
          end
        end
        chk("if_status", 32'(if_status), 32'(e_ifst));
        chk("mem_status", 32'(mem_status), 32'(e_memst));
        chk("ram_wr", 32'(ram_wr), 32'(e_wr));
        chk("ram_a", ram_a, e_a);
        chk("ram_dout", 32'(ram_dout), 32'(e_dout));
        chk("if_data", if_data, e_ifdata);
        chk("mem_rdata", mem_rdata, e_memrdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mem_access(input logic [2:0] rw, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] q, output int lat);
    mem_rw = rw; mem_addr = a; mem_wdata = wd; mem_quantity = q;
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      lat++;
      if (mem_status == ST_DONE) break;
    end
    chk("mem_done_timeout", 32'(mem_status), 32'(ST_DONE));
    mem_rw = 3'b000;
    $display("txn mem rw=%0d addr=%08h qty=%0d wdata=%08h latency=%0d rdata=%08h",
             rw, a, q, wd, lat, mem_rdata);
  endtask

  task automatic if_fetch(input logic [31:0] a, output int lat);
    if_req = 1'b1; if_addr = a;
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      lat++;
      if (if_status == ST_DONE) break;
    end
    chk("if_done_timeout", 32'(if_status), 32'(ST_DONE));
    if_req = 1'b0;
    $display("txn if fetch addr=%08h latency=%0d data=%08h", a, lat, if_data);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] q, input logic [31:0] exp, input int exp_lat);
    int lat;
    mem_access(3'b001, a, 32'h0, q, lat);
    chk("rd_latency", 32'(lat), 32'(exp_lat));
    chk("rd_data", mem_rdata, exp);
    idle(1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] q, input logic [31:0] wd,
                          input int n, input logic [7:0] last_byte);
    int lat, w0;
    logic [31:0] la, na;
    w0 = wr_cnt;
    mem_access(3'b010, a, wd, q, lat);
    idle(1);
    la = a + 32'(n) - 32'd1;
    na = a + 32'(n);
    chk("wr_latency", 32'(lat), 32'(n + 1));
    chk("wr_count", 32'(wr_cnt - w0), 32'(n));
    chk("wr_last_byte", 32'(ram[la[9:0]]), 32'(last_byte));
    chk("wr_no_overrun", 32'(ram[na[9:0]]), 32'h0);
  endtask

  initial begin
    int lat, w0, n_done;
    idle(2);
    ram_load = 1'b0;
    chk("rst_ram_wr", 32'(ram_wr), 32'h0);
    chk("rst_ram_a", ram_a, 32'h0);
    chk("rst_ram_dout", 32'(ram_dout), 32'h0);
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_if_status", 32'(if_status), 32'(ST_IDLE));
    chk("rst_mem_status", 32'(mem_status), 32'(ST_IDLE));
    rst = 1'b0;
    idle(1);

    // Loads: quantity mapping, little-endian assembly, zero upper bytes, address wrap.
    do_read(32'h00000100, 4'd4, 32'h44332211, 6);
    do_read(32'h00000102, 4'd1, 32'h00000033, 3);
    do_read(32'h00000100, 4'd3, 32'h44332211, 6);
    do_read(32'h00000101, 4'd0, 32'h00443322, 6);
    do_read(32'hFFFFFFFF, 4'd2, 32'h0000015A, 4);

    // Stores of 1, 4 and 2 bytes.
    do_write(32'h00000205, 4'd1, 32'h000000AB, 1, 8'hAB);
    do_write(32'h00000300, 4'd4, 32'h87654321, 4, 8'h87);
    do_write(32'h00000310, 4'd2, 32'hFFFF1234, 2, 8'h12);

    // Simultaneous IF and MEM requests: MEM wins, IF follows after one IDLE cycle.
    if_req = 1'b1; if_addr = 32'h00000020;
    mem_access(3'b001, 32'h00000010, 32'h0, 4'd2, lat);
    chk("arb_mem_latency", 32'(lat), 32'd4);
    chk("arb_mem_rdata", mem_rdata, 32'h0000BBAA);
    chk("arb_if_waits", 32'(if_status), 32'(ST_IDLE));
    if_fetch(32'h00000020, lat);
    chk("arb_if_latency", 32'(lat), 32'd7);
    chk("arb_if_data", if_data, 32'hDEADBEEF);
    idle(1);

    // Flush an IF read two cycles after acceptance.
    if_req = 1'b1; if_addr = 32'h00000000;
    @(negedge clk);
    chk("flush_busy", 32'(if_status), 32'(ST_BUSY));
    @(negedge clk);
    if_flush = 1'b1; if_req = 1'b0;
    @(negedge clk);
    if_flush = 1'b0;
    chk("flush_if_idle", 32'(if_status), 32'(ST_IDLE));
    chk("flush_mem_idle", 32'(mem_status), 32'(ST_IDLE));
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if_status == ST_DONE) n_done++;
    end
    chk("flush_no_done", 32'(n_done), 32'h0);
    chk("flush_ifdata_held", if_data, 32'hDEADBEEF);
    $display("txn if fetch addr=00000000 flushed");
    if_fetch(32'h00000004, lat);
    chk("refetch_latency", 32'(lat), 32'd6);
    chk("refetch_data", if_data, 32'h08070605);
    idle(1);

    // Reset during the third byte of a 4-byte store.
    w0 = wr_cnt;
    mem_rw = 3'b010; mem_addr = 32'h00000080; mem_wdata = 32'hDDCCBBAA; mem_quantity = 4'd4;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; mem_rw = 3'b000;
    @(negedge clk);
    chk("rstmid_ram_wr", 32'(ram_wr), 32'h0);
    chk("rstmid_if_status", 32'(if_status), 32'(ST_IDLE));
    chk("rstmid_mem_status", 32'(mem_status), 32'(ST_IDLE));
    rst = 1'b0;
    idle(2);
    chk("rstmid_wr_count", 32'(wr_cnt - w0), 32'd2);
    chk("rstmid_byte0", 32'(ram[10'h080]), 32'hAA);
    chk("rstmid_byte1", 32'(ram[10'h081]), 32'hBB);
    chk("rstmid_byte2", 32'(ram[10'h082]), 32'h00);
    chk("rstmid_byte3", 32'(ram[10'h083]), 32'h00);
    $display("txn mem write addr=00000080 aborted by reset, writes=%0d", wr_cnt - w0);

    // Write to the IO region with the output buffer full.
    io_buffer_full = 1'b1;
`ifdef MEMCTRL_IO_STALL_EN
    model_en = 1'b0;
    mem_rw = 3'b010; mem_addr = 32'h00030000; mem_wdata = 32'h000000C3; mem_quantity = 4'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_no_wr", 32'(ram_wr), 32'h0);
      chk("stall_busy", 32'(mem_status), 32'(ST_BUSY));
    end
    io_buffer_full = 1'b0;
    @(negedge clk);
    chk("stall_wr", 32'(ram_wr), 32'h1);
    chk("stall_wr_a", ram_a, 32'h00030000);
    chk("stall_wr_dout", 32'(ram_dout), 32'hC3);
    @(negedge clk);
    chk("stall_done", 32'(mem_status), 32'(ST_DONE));
    chk("stall_wr_end", 32'(ram_wr), 32'h0);
    mem_rw = 3'b000;
    $display("txn mem write addr=00030000 stalled 3 cycles");
`else
    mem_rw = 3'b010; mem_addr = 32'h00030000; mem_wdata = 32'h000000C3; mem_quantity = 4'd1;
    @(negedge clk);
    chk("io_wr_immediate", 32'(ram_wr), 32'h1);
    chk("io_wr_a", ram_a, 32'h00030000);
    @(negedge clk);
    chk("io_done", 32'(mem_status), 32'(ST_DONE));
    mem_rw = 3'b000;
    io_buffer_full = 1'b0;
    $display("txn mem write addr=00030000 issued at acceptance");
`endif
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
